// File: rtl/main_pkg.sv
// rtl/main_pkg.sv - shared widths, state enums and default timing constants for pmod_audio_main
package main_pkg;

    localparam int ADC_W = 14;   // SAR result width
    localparam int SER_W = 16;   // serial word width for both shift/latch chains

    localparam int SAMPLE_DIV_DEF  = 750;  // core cycles per audio sample
    localparam int SETTLE_CYC_DEF  = 4;    // wait from trial latch to comparator sample
    localparam int FIFO_STROBE_DEF = 4;    // nRD/nWD low time in core cycles

    localparam logic [SER_W-1:0] DAC_RESET_WORD = 16'h8000;  // mid-scale

    typedef enum logic [1:0] {
        SAR_IDLE,
        SAR_SHIFT,
        SAR_SETTLE,
        SAR_FINAL
    } sar_state_e;

    typedef enum logic [2:0] {
        FIFO_IDLE,
        FIFO_WR_SETUP,
        FIFO_WR_STROBE,
        FIFO_WR_HOLD,
        FIFO_RD_STROBE,
        FIFO_RD_RECOVER
    } fifo_state_e;

    // One-hot SAR bit mask; indices above ADC_W-1 yield zero.
    function automatic logic [ADC_W-1:0] sar_bit(input logic [3:0] idx);
        return ADC_W'(1) << idx;
    endfunction

endpackage

// File: rtl/serial_shifter.sv
// rtl/serial_shifter.sv - 16-bit load/shift/latch serializer driving Ser/SClk/LClk
//
// Ports:
//   clk_i, rst_ni : core clock, asynchronous active-low reset
//   load_i        : one-cycle pulse, captures data_i and starts a 34-cycle frame
//   data_i        : word to send, MSB first
//   ser_o         : serial data, only changes while sclk_o is low
//   sclk_o        : shift clock, 1 cycle low + 1 cycle high per bit
//   lclk_o        : latch clock, high for 2 cycles after bit 0 with sclk_o low
//   done_o        : one-cycle pulse after the latch pulse ends
module serial_shifter
    import main_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [SER_W-1:0] data_i,
    output logic             ser_o,
    output logic             sclk_o,
    output logic             lclk_o,
    output logic             done_o
);

    // Steps 0..2*SER_W-1 are bit phases (even = SClk low, odd = SClk high);
    // the final two steps hold LClk high.
    localparam int LAST_STEP = 2 * SER_W + 1;

    logic [SER_W-1:0] shreg_q;
    logic [5:0]       step_q;
    logic             busy_q;
    logic             ser_q;
    logic             sclk_q;
    logic             lclk_q;
    logic             done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shreg_q <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            ser_q   <= 1'b0;
            sclk_q  <= 1'b0;
            lclk_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load_i) begin
                shreg_q <= data_i;
                step_q  <= '0;
                busy_q  <= 1'b1;
                ser_q   <= data_i[SER_W-1];
                sclk_q  <= 1'b0;
                lclk_q  <= 1'b0;
            end else if (busy_q) begin
                if (step_q == 6'(LAST_STEP)) begin
                    busy_q <= 1'b0;
                    lclk_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    step_q <= step_q + 6'd1;
                    if (step_q + 6'd1 < 6'(2 * SER_W)) begin
                        sclk_q <= ~step_q[0];
                        // Entering a low phase: advance to the next bit.
                        if (step_q[0]) begin
                            shreg_q <= {shreg_q[SER_W-2:0], 1'b0};
                            ser_q   <= shreg_q[SER_W-2];
                        end
                    end else begin
                        sclk_q <= 1'b0;
                        lclk_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign ser_o  = ser_q;
    assign sclk_o = sclk_q;
    assign lclk_o = lclk_q;
    assign done_o = done_q;

endmodule

// File: rtl/pmod_audio_main.sv
// rtl/pmod_audio_main.sv - Pmod audio top: 14-bit SAR ADC, 16-bit serial DAC, FT245 FIFO bridge
//
// Optional feature macro: PLL_EN (core clock from PLL instance pll_36mh, else pin_clk_i).
//
// Ports:
//   pin_clk_i, reset_ni         : board clock, asynchronous active-low reset
//   ADC_SH_o                    : sample/hold (1 = hold during conversion)
//   ADC_Ser_o/SClk_o/LClk_o     : SAR trial-code shift/latch chain
//   ADC_Comp_i                  : comparator, 1 = trial code <= analog input
//   DAC_Ser_o/SClk_o/LClk_o     : DAC shift/latch chain
//   fifo_d0_io..fifo_d7_io      : FIFO data bus (d0 = LSB), high-Z unless writing
//   fifo_nRXF_i, fifo_nTXE_i    : FIFO receive-available / transmit-space flags
//   fifo_nRD_o, fifo_nWD_o      : FIFO read / write strobes
//   led_txerr_o, led_rxerr_o    : sticky overrun / underrun flags
module pmod_audio_main
    import main_pkg::*;
#(
    parameter int SAMPLE_DIV  = SAMPLE_DIV_DEF,
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int FIFO_STROBE = FIFO_STROBE_DEF
) (
    input  logic pin_clk_i,
    input  logic reset_ni,
    output logic ADC_SH_o,
    output logic ADC_Ser_o,
    output logic ADC_SClk_o,
    output logic ADC_LClk_o,
    input  logic ADC_Comp_i,
    output logic DAC_Ser_o,
    output logic DAC_SClk_o,
    output logic DAC_LClk_o,
    inout  wire  fifo_d0_io,
    inout  wire  fifo_d1_io,
    inout  wire  fifo_d2_io,
    inout  wire  fifo_d3_io,
    inout  wire  fifo_d4_io,
    inout  wire  fifo_d5_io,
    inout  wire  fifo_d6_io,
    inout  wire  fifo_d7_io,
    input  logic fifo_nRXF_i,
    input  logic fifo_nTXE_i,
    output logic fifo_nRD_o,
    output logic fifo_nWD_o,
    output logic led_txerr_o,
    output logic led_rxerr_o
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);

    logic clk;
    logic rst_n;

`ifdef PLL_EN
    pll pll_36mh (
        .clock_in  (pin_clk_i),
        .clock_out (clk)
    );
`else
    assign clk = pin_clk_i;
`endif

    assign rst_n = reset_ni;

    // ---------------------------------------------------------------
    // Input synchronizers and sample tick
    // ---------------------------------------------------------------
    logic [1:0]       comp_sync_q;
    logic [1:0]       ntxe_sync_q;
    logic [1:0]       nrxf_sync_q;
    logic [DIV_W-1:0] div_q;
    logic             tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            comp_sync_q <= 2'b00;
            ntxe_sync_q <= 2'b11;
            nrxf_sync_q <= 2'b11;
            div_q       <= '0;
        end else begin
            comp_sync_q <= {comp_sync_q[0], ADC_Comp_i};
            ntxe_sync_q <= {ntxe_sync_q[0], fifo_nTXE_i};
            nrxf_sync_q <= {nrxf_sync_q[0], fifo_nRXF_i};
            div_q       <= tick ? '0 : div_q + DIV_W'(1);
        end
    end

    assign tick = (div_q == DIV_W'(SAMPLE_DIV - 1));

    // ---------------------------------------------------------------
    // SAR conversion FSM
    // ---------------------------------------------------------------
    sar_state_e       sar_state_q;
    logic [ADC_W-1:0] sar_res_q;      // decided bits only, trial bit excluded
    logic [3:0]       sar_idx_q;
    logic [7:0]       settle_q;
    logic             adc_load_q;
    logic [SER_W-1:0] adc_data_q;
    logic             adc_sh_q;
    logic             res_valid_q;
    logic             adc_done;
    logic [ADC_W-1:0] sar_keep_d;
    logic [ADC_W-1:0] sar_next_trial_d;

    assign sar_keep_d       = comp_sync_q[1] ? (sar_res_q | sar_bit(sar_idx_q)) : sar_res_q;
    assign sar_next_trial_d = sar_keep_d | sar_bit(sar_idx_q - 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sar_state_q <= SAR_IDLE;
            sar_res_q   <= '0;
            sar_idx_q   <= '0;
            settle_q    <= '0;
            adc_load_q  <= 1'b0;
            adc_data_q  <= '0;
            adc_sh_q    <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            adc_load_q  <= 1'b0;
            res_valid_q <= 1'b0;
            case (sar_state_q)
                SAR_IDLE: begin
                    if (tick) begin
                        adc_sh_q    <= 1'b1;
                        sar_res_q   <= '0;
                        sar_idx_q   <= 4'(ADC_W - 1);
                        adc_data_q  <= {2'b00, sar_bit(4'(ADC_W - 1))};
                        adc_load_q  <= 1'b1;
                        sar_state_q <= SAR_SHIFT;
                    end
                end
                SAR_SHIFT: begin
                    if (adc_done) begin
                        settle_q    <= '0;
                        sar_state_q <= SAR_SETTLE;
                    end
                end
                SAR_SETTLE: begin
                    if (settle_q == 8'(SETTLE_CYC - 1)) begin
                        sar_res_q  <= sar_keep_d;
                        adc_load_q <= 1'b1;
                        if (sar_idx_q == 4'd0) begin
                            // Re-latch the final code so the resistor DAC holds the result.
                            adc_data_q  <= {2'b00, sar_keep_d};
                            sar_state_q <= SAR_FINAL;
                        end else begin
                            adc_data_q  <= {2'b00, sar_next_trial_d};
                            sar_idx_q   <= sar_idx_q - 4'd1;
                            sar_state_q <= SAR_SHIFT;
                        end
                    end else begin
                        settle_q <= settle_q + 8'd1;
                    end
                end
                SAR_FINAL: begin
                    if (adc_done) begin
                        adc_sh_q    <= 1'b0;
                        res_valid_q <= 1'b1;
                        sar_state_q <= SAR_IDLE;
                    end
                end
                default: sar_state_q <= SAR_IDLE;
            endcase
        end
    end

    serial_shifter u_adc_shifter (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .load_i (adc_load_q),
        .data_i (adc_data_q),
        .ser_o  (ADC_Ser_o),
        .sclk_o (ADC_SClk_o),
        .lclk_o (ADC_LClk_o),
        .done_o (adc_done)
    );

    assign ADC_SH_o = adc_sh_q;

    // ---------------------------------------------------------------
    // FIFO bus, transmit queue, receive pairing and DAC word
    // ---------------------------------------------------------------
    fifo_state_e      fifo_state_q;
    logic [7:0]       strobe_q;
    logic             bus_oe_q;
    logic [7:0]       bus_out_q;
    logic [7:0]       bus_in;
    logic             nrd_q;
    logic             nwd_q;
    logic [ADC_W-1:0] tx_data_q;
    logic             tx_pend_q;      // some byte of tx_data_q not yet started
    logic             tx_hi_q;        // next byte to send is the high byte
    logic             txerr_q;
    logic             rx_hi_q;        // next byte received is the high byte
    logic [7:0]       rx_lo_q;
    logic [SER_W-1:0] rx_word_q;
    logic             rx_new_q;       // completed pair waiting for a tick
    logic             rxerr_q;
    logic             tick_seen_q;    // first tick has no predecessor to miss
    logic [SER_W-1:0] dac_word_q;
    logic             dac_load_q;
    logic             dac_active_q;
    logic             dac_done;

    assign bus_in = {fifo_d7_io, fifo_d6_io, fifo_d5_io, fifo_d4_io,
                     fifo_d3_io, fifo_d2_io, fifo_d1_io, fifo_d0_io};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_state_q <= FIFO_IDLE;
            strobe_q     <= '0;
            bus_oe_q     <= 1'b0;
            bus_out_q    <= '0;
            nrd_q        <= 1'b1;
            nwd_q        <= 1'b1;
            tx_data_q    <= '0;
            tx_pend_q    <= 1'b0;
            tx_hi_q      <= 1'b0;
            txerr_q      <= 1'b0;
            rx_hi_q      <= 1'b0;
            rx_lo_q      <= '0;
            rx_word_q    <= '0;
            rx_new_q     <= 1'b0;
            rxerr_q      <= 1'b0;
            tick_seen_q  <= 1'b0;
            dac_word_q   <= DAC_RESET_WORD;
            dac_load_q   <= 1'b0;
            dac_active_q <= 1'b0;
        end else begin
            dac_load_q <= 1'b0;
            if (dac_load_q) begin
                dac_active_q <= 1'b1;
            end else if (dac_done) begin
                dac_active_q <= 1'b0;
            end

            if (tick) begin
                tick_seen_q <= 1'b1;
                rx_new_q    <= 1'b0;
                dac_load_q  <= ~dac_active_q;
                if (rx_new_q) begin
                    dac_word_q <= rx_word_q;
                end else if (tick_seen_q) begin
                    rxerr_q <= 1'b1;
                end
            end

            if (res_valid_q) begin
                if (tx_pend_q) begin
                    txerr_q <= 1'b1;
                end
                tx_data_q <= sar_res_q;
                tx_pend_q <= 1'b1;
                tx_hi_q   <= 1'b0;
            end

            case (fifo_state_q)
                FIFO_IDLE: begin
                    // A byte is committed when its write cycle starts; skip the cycle
                    // a new result lands so the replacement is not half-applied.
                    if (tx_pend_q && !ntxe_sync_q[1] && !res_valid_q) begin
                        bus_out_q <= tx_hi_q ? {2'b00, tx_data_q[ADC_W-1:8]} : tx_data_q[7:0];
                        bus_oe_q  <= 1'b1;
                        if (tx_hi_q) begin
                            tx_pend_q <= 1'b0;
                            tx_hi_q   <= 1'b0;
                        end else begin
                            tx_hi_q <= 1'b1;
                        end
                        fifo_state_q <= FIFO_WR_SETUP;
                    end else if (!nrxf_sync_q[1]) begin
                        nrd_q        <= 1'b0;
                        strobe_q     <= '0;
                        fifo_state_q <= FIFO_RD_STROBE;
                    end
                end
                FIFO_WR_SETUP: begin
                    nwd_q        <= 1'b0;
                    strobe_q     <= '0;
                    fifo_state_q <= FIFO_WR_STROBE;
                end
                FIFO_WR_STROBE: begin
                    if (strobe_q == 8'(FIFO_STROBE - 1)) begin
                        nwd_q        <= 1'b1;
                        fifo_state_q <= FIFO_WR_HOLD;
                    end else begin
                        strobe_q <= strobe_q + 8'd1;
                    end
                end
                FIFO_WR_HOLD: begin
                    bus_oe_q     <= 1'b0;
                    fifo_state_q <= FIFO_IDLE;
                end
                FIFO_RD_STROBE: begin
                    if (strobe_q == 8'(FIFO_STROBE - 1)) begin
                        nrd_q    <= 1'b1;
                        strobe_q <= '0;
                        if (rx_hi_q) begin
                            rx_word_q <= {bus_in, rx_lo_q};
                            rx_new_q  <= 1'b1;
                            rx_hi_q   <= 1'b0;
                        end else begin
                            rx_lo_q <= bus_in;
                            rx_hi_q <= 1'b1;
                        end
                        fifo_state_q <= FIFO_RD_RECOVER;
                    end else begin
                        strobe_q <= strobe_q + 8'd1;
                    end
                end
                FIFO_RD_RECOVER: begin
                    if (strobe_q == 8'd1) begin
                        fifo_state_q <= FIFO_IDLE;
                    end else begin
                        strobe_q <= strobe_q + 8'd1;
                    end
                end
                default: fifo_state_q <= FIFO_IDLE;
            endcase
        end
    end

    serial_shifter u_dac_shifter (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .load_i (dac_load_q),
        .data_i (dac_word_q),
        .ser_o  (DAC_Ser_o),
        .sclk_o (DAC_SClk_o),
        .lclk_o (DAC_LClk_o),
        .done_o (dac_done)
    );

    assign fifo_d0_io = bus_oe_q ? bus_out_q[0] : 1'bz;
    assign fifo_d1_io = bus_oe_q ? bus_out_q[1] : 1'bz;
    assign fifo_d2_io = bus_oe_q ? bus_out_q[2] : 1'bz;
    assign fifo_d3_io = bus_oe_q ? bus_out_q[3] : 1'bz;
    assign fifo_d4_io = bus_oe_q ? bus_out_q[4] : 1'bz;
    assign fifo_d5_io = bus_oe_q ? bus_out_q[5] : 1'bz;
    assign fifo_d6_io = bus_oe_q ? bus_out_q[6] : 1'bz;
    assign fifo_d7_io = bus_oe_q ? bus_out_q[7] : 1'bz;

    assign fifo_nRD_o  = nrd_q;
    assign fifo_nWD_o  = nwd_q;
    assign led_txerr_o = txerr_q;
    assign led_rxerr_o = rxerr_q;

endmodule

// File: tb/tb_pmod_audio_main.sv
// tb/tb_pmod_audio_main.sv - self-checking bench for pmod_audio_main with comparator, DAC and FIFO models
module tb_pmod_audio_main;

    logic pin_clk = 1'b0;
    logic reset_n = 1'b0;
    logic ADC_SH, ADC_Ser, ADC_SClk, ADC_LClk, ADC_Comp;
    logic DAC_Ser, DAC_SClk, DAC_LClk;
    logic nRXF, nRD, nWD, led_tx, led_rx;
    logic nTXE = 1'b0;
    wire  [7:0] fifo_d;

    int n_checks = 0;
    int n_err    = 0;

    // Analog model: comparator says 1 when latched code <= threshold.
    logic [15:0] thr       = 16'h0;
    logic        comp_zero = 1'b0;
    logic [15:0] adc_sr    = 16'h0;
    logic [15:0] adc_code  = 16'h0;
    logic [15:0] dac_sr    = 16'h0;
    logic [15:0] adc_lat[$];
    logic        adc_sh_at[$];
    logic [15:0] dac_lat[$];
    logic [7:0]  wr_q[$];

    // Receive side of the USB FIFO.
    logic [7:0] rx_mem[16];
    int         rx_wr = 0;
    int         rx_rd = 0;

    always #5 pin_clk = ~pin_clk;

    assign ADC_Comp = comp_zero ? 1'b0 : (adc_code <= thr);
    assign nRXF     = (rx_rd == rx_wr);
    assign fifo_d   = (!nRD) ? rx_mem[4'(rx_rd)] : 8'bz;

    always @(posedge ADC_SClk) adc_sr = {adc_sr[14:0], ADC_Ser};
    always @(posedge ADC_LClk) begin
        adc_code = adc_sr;
        adc_lat.push_back(adc_sr);
        adc_sh_at.push_back(ADC_SH);
    end
    always @(posedge DAC_SClk) dac_sr = {dac_sr[14:0], DAC_Ser};
    always @(posedge DAC_LClk) dac_lat.push_back(dac_sr);
    always @(negedge nWD) if (reset_n) wr_q.push_back(fifo_d);
    always @(posedge nRD) if (reset_n && rx_rd != rx_wr) rx_rd = rx_rd + 1;

    pmod_audio_main dut (
        .pin_clk_i   (pin_clk),
        .reset_ni    (reset_n),
        .ADC_SH_o    (ADC_SH),
        .ADC_Ser_o   (ADC_Ser),
        .ADC_SClk_o  (ADC_SClk),
        .ADC_LClk_o  (ADC_LClk),
        .ADC_Comp_i  (ADC_Comp),
        .DAC_Ser_o   (DAC_Ser),
        .DAC_SClk_o  (DAC_SClk),
        .DAC_LClk_o  (DAC_LClk),
        .fifo_d0_io  (fifo_d[0]),
        .fifo_d1_io  (fifo_d[1]),
        .fifo_d2_io  (fifo_d[2]),
        .fifo_d3_io  (fifo_d[3]),
        .fifo_d4_io  (fifo_d[4]),
        .fifo_d5_io  (fifo_d[5]),
        .fifo_d6_io  (fifo_d[6]),
        .fifo_d7_io  (fifo_d[7]),
        .fifo_nRXF_i (nRXF),
        .fifo_nTXE_i (nTXE),
        .fifo_nRD_o  (nRD),
        .fifo_nWD_o  (nWD),
        .led_txerr_o (led_tx),
        .led_rxerr_o (led_rx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] dac_last();
        return (dac_lat.size() > 0) ? dac_lat[dac_lat.size()-1] : 16'hDEAD;
    endfunction

    task automatic push_pair(input logic [15:0] w);
        rx_mem[4'(rx_wr)] = w[7:0];
        rx_wr = rx_wr + 1;
        rx_mem[4'(rx_wr)] = w[15:8];
        rx_wr = rx_wr + 1;
    endtask

    // Expected SAR outcome: largest 14-bit code the comparator accepts.
    function automatic logic [13:0] sar_expect(input logic [15:0] t, input logic z);
        if (z) return 14'h0;
        return (t > 16'h3FFF) ? 14'h3FFF : t[13:0];
    endfunction

    task automatic run_conv(input string tag, input logic [15:0] t, input logic z, input logic expect_wr);
        logic [13:0] exp;
        int base;
        int wb;
        exp = sar_expect(t, z);
        thr = t;
        comp_zero = z;
        base = adc_lat.size();
        wb = wr_q.size();
        for (int c = 0; c < 1600 && adc_lat.size() < base + 15; c++) @(negedge pin_clk);
        check({tag, "_conv_done"}, 32'(adc_lat.size() >= base + 15), 32'd1);
        if (adc_lat.size() >= base + 15) begin
            check({tag, "_first_trial"}, 32'(adc_lat[base]), 32'h2000);
            check({tag, "_final_latch"}, 32'(adc_lat[base+14]), {18'h0, exp});
            check({tag, "_sh_hold"}, 32'(adc_sh_at[base]), 32'd1);
        end
        if (expect_wr) begin
            for (int c = 0; c < 200 && wr_q.size() < wb + 2; c++) @(negedge pin_clk);
            check({tag, "_write_count"}, 32'(wr_q.size() - wb), 32'd2);
            if (wr_q.size() >= wb + 2) begin
                check({tag, "_byte_lo"}, 32'(wr_q[wb]), {24'h0, exp[7:0]});
                check({tag, "_byte_hi"}, 32'(wr_q[wb+1]), {26'h0, exp[13:8]});
            end
        end else begin
            repeat (30) @(negedge pin_clk);
            check({tag, "_no_write"}, 32'(wr_q.size() - wb), 32'd0);
        end
        check({tag, "_sh_track"}, 32'(ADC_SH), 32'd0);
    endtask

    initial begin
        logic [15:0] t;
        logic [15:0] p;
        int wb0;
        int base;

        repeat (3) @(negedge pin_clk);
        check("rst_sh", 32'(ADC_SH), 32'd0);
        check("rst_adc_serial", 32'({ADC_Ser, ADC_SClk, ADC_LClk}), 32'd0);
        check("rst_dac_serial", 32'({DAC_Ser, DAC_SClk, DAC_LClk}), 32'd0);
        check("rst_strobes", 32'({nRD, nWD}), 32'd3);
        check("rst_leds", 32'({led_tx, led_rx}), 32'd0);

        reset_n = 1'b1;
        push_pair(16'h7FAF);
        run_conv("c2a52", 16'h2A52, 1'b0, 1'b1);
        check("dac_first_pair", 32'(dac_last()), 32'h7FAF);
        check("rxerr_tick1", 32'(led_rx), 32'd0);

        t = 16'($urandom_range(0, 16383));
        run_conv("rand0", t, 1'b0, 1'b1);
        check("dac_reuse", 32'(dac_last()), 32'h7FAF);
        check("rxerr_tick2", 32'(led_rx), 32'd1);

        for (int i = 0; i < 3; i++) begin
            p = 16'($urandom);
            push_pair(p);
            t = 16'($urandom_range(0, 20000));
            run_conv("rand_loop", t, 1'b0, 1'b1);
            check("dac_rand_pair", 32'(dac_last()), 32'(p));
        end

        run_conv("comp_one", 16'hFFFF, 1'b0, 1'b1);
        run_conv("comp_zero", 16'h1234, 1'b1, 1'b1);
        check("txerr_clear", 32'(led_tx), 32'd0);

        nTXE = 1'b1;
        wb0 = wr_q.size();
        t = 16'($urandom_range(0, 16383));
        run_conv("txe_a", t, 1'b0, 1'b0);
        check("txerr_one_pending", 32'(led_tx), 32'd0);
        run_conv("txe_b", t, 1'b0, 1'b0);
        check("txerr_overrun", 32'(led_tx), 32'd1);
        check("nwd_never", 32'(wr_q.size() - wb0), 32'd0);
        nTXE = 1'b0;
        for (int c = 0; c < 200 && wr_q.size() < wb0 + 2; c++) @(negedge pin_clk);
        check("txe_drain_count", 32'(wr_q.size() - wb0), 32'd2);
        if (wr_q.size() >= wb0 + 2) begin
            check("txe_drain_lo", 32'(wr_q[wb0]), {24'h0, t[7:0]});
            check("txe_drain_hi", 32'(wr_q[wb0+1]), {26'h0, t[13:8]});
        end

        base = adc_lat.size();
        thr = 16'($urandom_range(0, 16383));
        for (int c = 0; c < 1600 && adc_lat.size() < base + 3; c++) @(negedge pin_clk);
        check("mid_conv_reached", 32'(adc_lat.size() >= base + 3), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_sh", 32'(ADC_SH), 32'd0);
        check("arst_adc_serial", 32'({ADC_Ser, ADC_SClk, ADC_LClk}), 32'd0);
        check("arst_dac_serial", 32'({DAC_Ser, DAC_SClk, DAC_LClk}), 32'd0);
        check("arst_strobes", 32'({nRD, nWD}), 32'd3);
        check("arst_leds", 32'({led_tx, led_rx}), 32'd0);
        repeat (4) @(negedge pin_clk);
        reset_n = 1'b1;

        t = 16'($urandom_range(0, 16383));
        run_conv("post_rst", t, 1'b0, 1'b1);
        check("dac_reset_word", 32'(dac_last()), 32'h8000);
        check("rxerr_post_tick1", 32'(led_rx), 32'd0);
        t = 16'($urandom_range(0, 16383));
        run_conv("post_rst2", t, 1'b0, 1'b1);
        check("dac_reset_reuse", 32'(dac_last()), 32'h8000);
        check("rxerr_post_tick2", 32'(led_rx), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/pmod_audio_main.md
# pmod_audio_main

Top level of the iCEbreaker Pmod audio interface: a 14-bit successive-approximation ADC and a 16-bit serial DAC, bridged to an FT245-style asynchronous USB FIFO. The SAR ADC is built from an external 16-bit shift/latch register driving a resistor DAC, plus an external comparator. The block is the FPGA top level and connects directly to package pins.

## Interface
- SAMPLE_DIV, 750: core cycles per audio sample (48 kHz at 36 MHz).
- SETTLE_CYC, 4: core cycles from ADC latch to comparator sample.
- FIFO_STROBE, 4: core cycles nRD/nWD held low.
- pin_clk_i  in  1  board clock; the core clock is derived from it (see Configuration).
- reset_ni  in  1  asynchronous, active-low reset.
- ADC_SH_o  out  1  sample/hold control: 0 = track, 1 = hold.
- ADC_Ser_o, ADC_SClk_o, ADC_LClk_o  out  1 each  SAR trial-code serial data, shift clock, latch clock.
- ADC_Comp_i  in  1  comparator: 1 = latched trial code ≤ analog input.
- DAC_Ser_o, DAC_SClk_o, DAC_LClk_o  out  1 each  DAC serial data, shift clock, latch clock.
- fifo_d0_io..fifo_d7_io  inout  1 each  FIFO data bus; d0 is the LSB.
- fifo_nRXF_i  in  1  low = receive byte available.
- fifo_nTXE_i  in  1  low = transmit space available.
- fifo_nRD_o  out  1  active-low read strobe.
- fifo_nWD_o  out  1  active-low write strobe.
- led_txerr_o, led_rxerr_o  out  1 each  sticky error flags.

## Operation
- Sample tick every SAMPLE_DIV core cycles, counted from reset release. At each tick:
  - load the current DAC word into the DAC serializer;
  - set ADC_SH_o = 1 and start a conversion.
- SAR conversion, MSB first:
  - result starts at 0.
  - For bit i = 13 down to 0: trial = result | (1<<i). Shift {2'b00, trial[13:0]} out MSB first, pulse LClk, wait SETTLE_CYC, sample ADC_Comp_i. Keep bit i if the sample is 1, otherwise clear it.
  - After bit 0, shift and latch the final result once more, set ADC_SH_o = 0, and queue the result for transmit.
- Transmit: bytes {result[7:0]} then {2'b00, result[13:8]}, one byte per write cycle, sent only while nTXE is low.
  - A new result arriving while the previous one is unsent sets led_txerr_o; the new result replaces the old one.
- Receive: while nRXF is low and no write is in progress, perform read cycles. Bytes pair low byte first into a 16-bit pending DAC word.
  - A completed pair becomes the DAC word at the next tick.
  - A tick with no new completed pair since the previous tick sets led_rxerr_o; the previous DAC word is reused.
- Writes take priority over reads when both are pending. Bus arbitration happens only between cycles.
- Both LED flags are sticky until reset.

## Timing
- Serial links, per bit: 1 cycle with SClk = 0 and data valid, then 1 cycle with SClk = 1. Data changes only while SClk is low.
- LClk is high for 2 cycles after the 16th bit, with SClk low.
- One SAR trial takes 32 + 2 + SETTLE_CYC cycles. A full conversion must complete within SAMPLE_DIV.
- FIFO read cycle: nRD low for FIFO_STROBE cycles, data sampled on the last low cycle, then nRD high for at least 2 cycles.
- FIFO write cycle: drive data 1 cycle before nWD falls, nWD low for FIFO_STROBE cycles, release the bus 1 cycle after nWD rises.
- The data bus is high-Z whenever no write cycle is active.
- Reset values:
  - all serial outputs 0;
  - ADC_SH_o = 0;
  - nRD = nWD = 1;
  - bus high-Z;
  - LEDs 0;
  - DAC word 16'h8000;
  - rx byte phase = low byte;
  - pending flags cleared.
- Reset mid-operation aborts any conversion or FIFO cycle immediately.

## Configuration
- PLL_EN defined: the core clock is the output `clock_out` of a PLL instance named `pll_36mh`, 36 MHz from pin_clk_i.
- PLL_EN undefined: the core clock is pin_clk_i directly.

## Structure
- Package main_pkg holds:
  - the ADC width (14) and serial word width (16);
  - the SAR and FIFO state enums;
  - the default parameter constants.
- One sub-module, serial_shifter: 16-bit load/shift/latch serializer producing Ser/SClk/LClk. It is instantiated for both the ADC and the DAC.

## Test plan
- Comparator model (code ≤ 16'h2A52) -> first latched trial 16'h2000; final latch 16'h2A52; FIFO writes 8'h52 then 8'h2A.
- nRXF low, bus driving 8'hAF then 8'h7F -> the DAC latch receives 16'h7FAF at the following tick.
- No bytes received -> DAC latch receives 16'h8000 at the first tick; led_rxerr_o = 1 at the second tick.
- nTXE held high across two conversions -> led_txerr_o = 1, and nWD_o never asserted.
- Reset asserted mid-conversion -> all outputs return to their reset values asynchronously; the next conversion after release starts cleanly from trial 16'h2000.
- Comparator tied to 1 gives result 14'h3FFF; comparator tied to 0 gives 14'h0000.
